// File: rtl/rule_unpacker_pkg.sv
// Shared types and helpers for the rule unpacker: metadata record, lane geometry,
// FSM encoding and lane-decode functions.
package struct_s;

  localparam int RULE_ID_WIDTH    = 16;
  localparam int RULES_PER_WORD   = 8;
  localparam int MATCH_DATA_WIDTH = RULE_ID_WIDTH * RULES_PER_WORD;
  localparam int LANE_W           = $clog2(RULES_PER_WORD);

  typedef struct packed {
    logic [15:0] pkt_id;
    logic [15:0] flow_id;
  } metadata_t;

  localparam int META_WIDTH = $bits(metadata_t);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_UNPACK    = 2'd1,
    ST_WAIT_META = 2'd2
  } unpack_state_t;

  // A lane is occupied when its rule ID is nonzero.
  function automatic logic [RULES_PER_WORD-1:0] lane_mask(input logic [MATCH_DATA_WIDTH-1:0] data);
    for (int k = 0; k < RULES_PER_WORD; k++) begin
      lane_mask[k] = |data[k*RULE_ID_WIDTH +: RULE_ID_WIDTH];
    end
  endfunction

  function automatic logic [LANE_W-1:0] lowest_lane(input logic [RULES_PER_WORD-1:0] mask);
    lowest_lane = '0;
    for (int k = RULES_PER_WORD - 1; k >= 0; k--) begin
      if (mask[k]) begin
        lowest_lane = LANE_W'(k);
      end
    end
  endfunction

  function automatic logic [RULE_ID_WIDTH-1:0] lane_id(input logic [MATCH_DATA_WIDTH-1:0] data,
                                                       input logic [LANE_W-1:0]           lane);
    lane_id = '0;
    for (int k = 0; k < RULES_PER_WORD; k++) begin
      if (LANE_W'(k) == lane) begin
        lane_id = data[k*RULE_ID_WIDTH +: RULE_ID_WIDTH];
      end
    end
  endfunction

endpackage

// File: rtl/rule_unpack_fifo.sv
// Single-clock show-ahead FIFO with occupancy output. A write into a full FIFO is
// accepted only when a pop happens in the same cycle; otherwise it is dropped.
module rule_unpack_fifo #(
  parameter int WIDTH = 129,
  parameter int DEPTH = 32,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             drop,
  output logic [CNT_W-1:0] count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             full;
  logic             push;
  logic             pop;

  always_comb begin
    full    = (count == CNT_W'(DEPTH));
    pop     = rd_en && (count != '0);
    push    = wr_en && (!full || pop);
    drop    = wr_en && !push;
    rd_data = mem[rd_ptr];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; occupancy alone defines which entries are live.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      mem[wr_ptr] <= wr_data;
    end
  end

endmodule

// File: rtl/rule_unpacker.sv
// Unpacks 8-lane match words into one rule ID per output beat, closing each packet
// with a last beat that carries the packet metadata.
module rule_unpacker
  import struct_s::*;
#(
  parameter int FIFO_DEPTH = 32,
  parameter int AF_LEVEL   = 24
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_match_valid,
  input  logic [MATCH_DATA_WIDTH-1:0] in_match_data,
  input  logic                        in_match_last,
  input  logic                        in_meta_valid,
  input  metadata_t                   in_meta_data,
  output logic                        out_match_almost_full,
  output logic                        out_rule_valid,
  output logic [RULE_ID_WIDTH-1:0]    out_rule_id,
  output logic                        out_rule_last,
  output metadata_t                   out_meta_data,
  input  logic                        out_rule_ready,
  output logic [31:0]                 stat_rule_cnt,
  output logic [31:0]                 stat_pkt_cnt,
  output logic [31:0]                 stat_drop_cnt
);

  localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);
  localparam int MATCH_W = MATCH_DATA_WIDTH + 1;
  localparam logic [CNT_W-1:0] AF_THRESH = CNT_W'(AF_LEVEL);

  unpack_state_t               state, next_state;
  logic [RULES_PER_WORD-1:0]   mask, mask_next, head_mask, rest_mask;
  logic [MATCH_DATA_WIDTH-1:0] word, word_next;
  logic [LANE_W-1:0]           lane;
  logic [MATCH_W-1:0]          match_head;
  logic [META_WIDTH-1:0]       meta_head;
  logic [CNT_W-1:0]            match_count, meta_count, match_level_next;
  logic                        match_pop, meta_pop, match_drop, meta_drop;
  logic                        out_free, load, load_last;
  logic [RULE_ID_WIDTH-1:0]    load_id;
  metadata_t                   load_meta;
  logic [32:0]                 drop_sum;

  rule_unpack_fifo #(.WIDTH(MATCH_W), .DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)) u_match_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (in_match_valid),
    .wr_data ({in_match_last, in_match_data}),
    .rd_en   (match_pop),
    .rd_data (match_head),
    .drop    (match_drop),
    .count   (match_count)
  );

  rule_unpack_fifo #(.WIDTH(META_WIDTH), .DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)) u_meta_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (in_meta_valid),
    .wr_data (in_meta_data),
    .rd_en   (meta_pop),
    .rd_data (meta_head),
    .drop    (meta_drop),
    .count   (meta_count)
  );

  // IDLE emits the first lane directly when the output is free, giving two-cycle latency.
  always_comb begin
    next_state = state;
    mask_next  = mask;
    word_next  = word;
    match_pop  = 1'b0;
    meta_pop   = 1'b0;
    load       = 1'b0;
    load_id    = '0;
    load_last  = 1'b0;
    load_meta  = '0;
    lane       = '0;
    rest_mask  = '0;
    out_free   = !out_rule_valid || out_rule_ready;
    head_mask  = lane_mask(match_head[MATCH_DATA_WIDTH-1:0]);
    case (state)
      ST_IDLE: begin
        if (match_count == '0) begin
          next_state = ST_IDLE;
        end else if (match_head[MATCH_W-1]) begin
          next_state = ST_WAIT_META;
        end else begin
          match_pop       = 1'b1;
          word_next       = match_head[MATCH_DATA_WIDTH-1:0];
          mask_next       = head_mask;
          lane            = lowest_lane(head_mask);
          rest_mask       = head_mask;
          rest_mask[lane] = 1'b0;
          if (head_mask == '0) begin
            next_state = ST_IDLE;
          end else if (out_free) begin
            load       = 1'b1;
            load_id    = lane_id(match_head[MATCH_DATA_WIDTH-1:0], lane);
            mask_next  = rest_mask;
            next_state = (rest_mask == '0) ? ST_IDLE : ST_UNPACK;
          end else begin
            next_state = ST_UNPACK;
          end
        end
      end
      ST_UNPACK: begin
        lane            = lowest_lane(mask);
        rest_mask       = mask;
        rest_mask[lane] = 1'b0;
        if (out_free) begin
          load       = 1'b1;
          load_id    = lane_id(word, lane);
          mask_next  = rest_mask;
          next_state = (rest_mask == '0) ? ST_IDLE : ST_UNPACK;
        end else begin
          next_state = ST_UNPACK;
        end
      end
      ST_WAIT_META: begin
        if ((meta_count != '0) && out_free) begin
          match_pop  = 1'b1;
          meta_pop   = 1'b1;
          load       = 1'b1;
          load_last  = 1'b1;
          load_meta  = metadata_t'(meta_head);
          next_state = ST_IDLE;
        end else begin
          next_state = ST_WAIT_META;
        end
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
    match_level_next = match_count + CNT_W'(in_match_valid && !match_drop) - CNT_W'(match_pop);
    drop_sum = {1'b0, stat_drop_cnt} + 33'(match_drop) + 33'(meta_drop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state                 <= ST_IDLE;
      mask                  <= '0;
      word                  <= '0;
      out_match_almost_full <= 1'b0;
      out_rule_valid        <= 1'b0;
      out_rule_id           <= '0;
      out_rule_last         <= 1'b0;
      out_meta_data         <= '0;
      stat_rule_cnt         <= 32'd0;
      stat_pkt_cnt          <= 32'd0;
      stat_drop_cnt         <= 32'd0;
    end else begin
      state                 <= next_state;
      mask                  <= mask_next;
      word                  <= word_next;
      out_match_almost_full <= (match_level_next >= AF_THRESH);
      if (load) begin
        out_rule_valid <= 1'b1;
        out_rule_id    <= load_id;
        out_rule_last  <= load_last;
        out_meta_data  <= load_meta;
      end else if (out_rule_ready) begin
        out_rule_valid <= 1'b0;
      end
      if (out_rule_valid && out_rule_ready && !out_rule_last) begin
        stat_rule_cnt <= stat_rule_cnt + 32'd1;
      end
      if (out_rule_valid && out_rule_ready && out_rule_last) begin
        stat_pkt_cnt <= stat_pkt_cnt + 32'd1;
      end
      // Saturate: both FIFOs may drop in the same cycle.
      stat_drop_cnt <= drop_sum[32] ? 32'hFFFF_FFFF : drop_sum[31:0];
    end
  end

endmodule

// File: tb/tb_rule_unpacker.sv
// Directed self-checking bench for rule_unpacker: reset, unpack order, latency,
// stalls, almost-full/drop, late metadata and mid-packet reset.
module tb_rule_unpacker;
  import struct_s::*;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_match_valid;
  logic [127:0] in_match_data;
  logic         in_match_last;
  logic         in_meta_valid;
  metadata_t    in_meta_data;
  logic         out_match_almost_full;
  logic         out_rule_valid;
  logic [15:0]  out_rule_id;
  logic         out_rule_last;
  metadata_t    out_meta_data;
  logic         out_rule_ready;
  logic [31:0]  stat_rule_cnt, stat_pkt_cnt, stat_drop_cnt;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  typedef struct {
    logic [15:0] id;
    logic        last;
    logic [15:0] pkt;
    int          cyc;
  } beat_t;
  beat_t q[$];

  rule_unpacker dut (
    .clk                   (clk),
    .rst                   (rst),
    .in_match_valid        (in_match_valid),
    .in_match_data         (in_match_data),
    .in_match_last         (in_match_last),
    .in_meta_valid         (in_meta_valid),
    .in_meta_data          (in_meta_data),
    .out_match_almost_full (out_match_almost_full),
    .out_rule_valid        (out_rule_valid),
    .out_rule_id           (out_rule_id),
    .out_rule_last         (out_rule_last),
    .out_meta_data         (out_meta_data),
    .out_rule_ready        (out_rule_ready),
    .stat_rule_cnt         (stat_rule_cnt),
    .stat_pkt_cnt          (stat_pkt_cnt),
    .stat_drop_cnt         (stat_drop_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every accepted output beat with the cycle it was presented in.
  always @(negedge clk) begin
    if (!rst && out_rule_valid && out_rule_ready) begin
      q.push_back('{out_rule_id, out_rule_last, out_meta_data.pkt_id, cyc});
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_match_valid = 1'b0;
    in_match_data  = '0;
    in_match_last  = 1'b0;
    in_meta_valid  = 1'b0;
    in_meta_data   = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    out_rule_ready = 1'b1;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    q.delete();
  endtask

  task automatic send_word(input logic [127:0] d, input logic last);
    in_match_valid = 1'b1;
    in_match_data  = d;
    in_match_last  = last;
    step();
    in_match_valid = 1'b0;
    in_match_data  = '0;
    in_match_last  = 1'b0;
  endtask

  task automatic send_meta(input logic [15:0] pkt);
    in_meta_valid       = 1'b1;
    in_meta_data.pkt_id = pkt;
    in_meta_data.flow_id = 16'hBEEF;
    step();
    in_meta_valid = 1'b0;
    in_meta_data  = '0;
  endtask

  task automatic wait_beats(input int n, input int budget);
    for (int i = 0; i < budget && q.size() < n; i++) step();
  endtask

  task automatic test_reset();
    idle_inputs();
    out_rule_ready = 1'b1;
    rst = 1'b1;
    in_match_valid = 1'b1;
    in_match_data  = {8{16'h1234}};
    in_meta_valid  = 1'b1;
    repeat (3) step();
    checks++; if (out_rule_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", out_rule_valid); end
    checks++; if (out_rule_id !== 16'h0 || out_rule_last !== 1'b0) begin errors++; $display("FAIL reset_id_last: got %h/%b want 0/0", out_rule_id, out_rule_last); end
    checks++; if (out_meta_data !== '0) begin errors++; $display("FAIL reset_meta: got %h want 0", out_meta_data); end
    checks++; if (out_match_almost_full !== 1'b0) begin errors++; $display("FAIL reset_af: got %b want 0", out_match_almost_full); end
    checks++; if (stat_rule_cnt !== 32'd0 || stat_pkt_cnt !== 32'd0 || stat_drop_cnt !== 32'd0) begin errors++; $display("FAIL reset_stats: got %0d/%0d/%0d want 0/0/0", stat_rule_cnt, stat_pkt_cnt, stat_drop_cnt); end
    idle_inputs();
    rst = 1'b0;
    q.delete();
    repeat (5) step();
    checks++; if (q.size() != 0) begin errors++; $display("FAIL reset_inputs_ignored: got %0d beats want 0", q.size()); end
  endtask

  task automatic test_basic();
    logic [127:0] d;
    int n0;
    do_reset();
    d = '0;
    d[15:0]  = 16'h0003;
    d[95:80] = 16'h0011;
    n0 = cyc;
    send_word(d, 1'b0);
    send_word({8{16'hFFFF}}, 1'b1);
    send_meta(16'd7);
    wait_beats(3, 30);
    checks++; if (q.size() != 3) begin errors++; $display("FAIL basic_count: got %0d want 3", q.size()); end
    if (q.size() == 3) begin
      checks++; if (q[0].id !== 16'h0003 || q[0].last !== 1'b0) begin errors++; $display("FAIL basic_beat0: got %h/%b want 0003/0", q[0].id, q[0].last); end
      checks++; if (q[1].id !== 16'h0011 || q[1].last !== 1'b0) begin errors++; $display("FAIL basic_beat1: got %h/%b want 0011/0", q[1].id, q[1].last); end
      checks++; if (q[2].id !== 16'h0 || q[2].last !== 1'b1 || q[2].pkt !== 16'd7) begin errors++; $display("FAIL basic_last: got %h/%b/%0d want 0/1/7", q[2].id, q[2].last, q[2].pkt); end
      checks++; if (q[0].cyc != n0 + 2) begin errors++; $display("FAIL basic_latency: got %0d want %0d", q[0].cyc - n0, 2); end
    end
    checks++; if (stat_rule_cnt !== 32'd2 || stat_pkt_cnt !== 32'd1) begin errors++; $display("FAIL basic_stats: got %0d/%0d want 2/1", stat_rule_cnt, stat_pkt_cnt); end
  endtask

  task automatic test_empty_word();
    do_reset();
    send_word('0, 1'b0);
    send_word('0, 1'b1);
    send_meta(16'd9);
    wait_beats(1, 30);
    repeat (5) step();
    checks++; if (q.size() != 1) begin errors++; $display("FAIL empty_count: got %0d want 1", q.size()); end
    if (q.size() >= 1) begin
      checks++; if (q[0].id !== 16'h0 || q[0].last !== 1'b1 || q[0].pkt !== 16'd9) begin errors++; $display("FAIL empty_last: got %h/%b/%0d want 0/1/9", q[0].id, q[0].last, q[0].pkt); end
    end
    checks++; if (stat_rule_cnt !== 32'd0 || stat_pkt_cnt !== 32'd1) begin errors++; $display("FAIL empty_stats: got %0d/%0d want 0/1", stat_rule_cnt, stat_pkt_cnt); end
  endtask

  task automatic test_back_to_back();
    logic [127:0] a, b;
    do_reset();
    a = '0; a[31:16] = 16'h0101; a[63:48]   = 16'h0303;
    b = '0; b[15:0]  = 16'h0404; b[127:112] = 16'h0808;
    send_word(a, 1'b0);
    send_word(b, 1'b0);
    in_meta_valid = 1'b1;
    in_meta_data.pkt_id = 16'h0033;
    send_word('0, 1'b1);
    idle_inputs();
    wait_beats(5, 30);
    checks++; if (q.size() != 5) begin errors++; $display("FAIL b2b_count: got %0d want 5", q.size()); end
    if (q.size() == 5) begin
      checks++; if (q[0].id !== 16'h0101 || q[1].id !== 16'h0303 || q[2].id !== 16'h0404 || q[3].id !== 16'h0808) begin errors++; $display("FAIL b2b_order: got %h %h %h %h want 0101 0303 0404 0808", q[0].id, q[1].id, q[2].id, q[3].id); end
      checks++; if (q[3].cyc - q[0].cyc != 3) begin errors++; $display("FAIL b2b_throughput: got %0d cycles want 3", q[3].cyc - q[0].cyc); end
      checks++; if (q[4].last !== 1'b1 || q[4].pkt !== 16'h0033) begin errors++; $display("FAIL b2b_last: got %b/%h want 1/0033", q[4].last, q[4].pkt); end
    end
  endtask

  task automatic test_stall();
    logic [127:0] d;
    logic pv, pr, pl;
    logic [15:0] pid;
    do_reset();
    out_rule_ready = 1'b0;
    for (int k = 0; k < 8; k++) d[k*16 +: 16] = 16'(k + 1);
    send_word(d, 1'b0);
    send_word('0, 1'b1);
    send_meta(16'h0021);
    pv = 1'b0; pr = 1'b1; pl = 1'b0; pid = '0;
    for (int i = 0; i < 60 && q.size() < 9; i++) begin
      if (pv && !pr) begin
        checks++;
        if (out_rule_valid !== 1'b1 || out_rule_id !== pid || out_rule_last !== pl) begin
          errors++; $display("FAIL stall_hold: got %b/%h/%b want 1/%h/%b", out_rule_valid, out_rule_id, out_rule_last, pid, pl);
        end
      end
      pv = out_rule_valid; pid = out_rule_id; pl = out_rule_last;
      out_rule_ready = (i % 2 == 0);
      pr = out_rule_ready;
      step();
    end
    out_rule_ready = 1'b1;
    checks++; if (q.size() != 9) begin errors++; $display("FAIL stall_count: got %0d want 9", q.size()); end
    if (q.size() == 9) begin
      for (int k = 0; k < 8; k++) begin
        checks++; if (q[k].id !== 16'(k + 1) || q[k].last !== 1'b0) begin errors++; $display("FAIL stall_order: beat %0d got %h want %h", k, q[k].id, 16'(k + 1)); end
      end
      checks++; if (q[8].last !== 1'b1 || q[8].pkt !== 16'h0021) begin errors++; $display("FAIL stall_last: got %b/%h want 1/0021", q[8].last, q[8].pkt); end
    end
  endtask

  task automatic test_almost_full();
    do_reset();
    out_rule_ready = 1'b0;
    for (int i = 0; i <= 56; i++) begin
      in_match_valid = 1'b1;
      in_match_data  = (i == 0) ? 128'h0 : 128'(i);
      in_match_last  = (i == 0);
      step();
      if (i == 22) begin
        checks++; if (out_match_almost_full !== 1'b0) begin errors++; $display("FAIL af_below: got %b want 0", out_match_almost_full); end
      end
      if (i == 23) begin
        checks++; if (out_match_almost_full !== 1'b1) begin errors++; $display("FAIL af_at_level: got %b want 1", out_match_almost_full); end
      end
    end
    idle_inputs();
    step();
    checks++; if (stat_drop_cnt !== 32'd25) begin errors++; $display("FAIL af_drop_cnt: got %0d want 25", stat_drop_cnt); end
    checks++; if (out_rule_valid !== 1'b0) begin errors++; $display("FAIL af_wait_meta: got valid %b want 0", out_rule_valid); end
    out_rule_ready = 1'b1;
    send_meta(16'h0055);
    wait_beats(32, 120);
    repeat (3) step();
    checks++; if (q.size() != 32) begin errors++; $display("FAIL af_drain_count: got %0d want 32", q.size()); end
    if (q.size() == 32) begin
      checks++; if (q[0].last !== 1'b1 || q[0].pkt !== 16'h0055) begin errors++; $display("FAIL af_drain_last: got %b/%h want 1/0055", q[0].last, q[0].pkt); end
      for (int j = 1; j < 32; j++) begin
        checks++; if (q[j].id !== 16'(j) || q[j].last !== 1'b0) begin errors++; $display("FAIL af_drain_order: beat %0d got %h want %h", j, q[j].id, 16'(j)); end
      end
    end
    checks++; if (out_match_almost_full !== 1'b0) begin errors++; $display("FAIL af_clear: got %b want 0", out_match_almost_full); end
    checks++; if (stat_rule_cnt !== 32'd31 || stat_pkt_cnt !== 32'd1) begin errors++; $display("FAIL af_stats: got %0d/%0d want 31/1", stat_rule_cnt, stat_pkt_cnt); end
  endtask

  task automatic test_late_meta();
    int bad;
    int m;
    do_reset();
    send_word('0, 1'b1);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (out_rule_valid !== 1'b0) bad++;
      step();
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL late_no_output: got %0d valid cycles want 0", bad); end
    m = cyc;
    send_meta(16'h000A);
    wait_beats(1, 20);
    checks++; if (q.size() != 1) begin errors++; $display("FAIL late_count: got %0d want 1", q.size()); end
    if (q.size() == 1) begin
      checks++; if (q[0].cyc != m + 2) begin errors++; $display("FAIL late_timing: got %0d want %0d", q[0].cyc - m, 2); end
      checks++; if (q[0].last !== 1'b1 || q[0].pkt !== 16'h000A) begin errors++; $display("FAIL late_beat: got %b/%h want 1/000a", q[0].last, q[0].pkt); end
    end
  endtask

  task automatic test_reset_mid();
    logic [127:0] d;
    do_reset();
    for (int k = 0; k < 8; k++) d[k*16 +: 16] = 16'(k + 1);
    send_word(d, 1'b0);
    wait_beats(3, 20);
    rst = 1'b1;
    out_rule_ready = 1'b0;
    checks++; if (stat_rule_cnt !== 32'd3) begin errors++; $display("FAIL midrst_pre_cnt: got %0d want 3", stat_rule_cnt); end
    step();
    checks++; if (out_rule_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b want 0", out_rule_valid); end
    checks++; if (stat_rule_cnt !== 32'd0 || stat_pkt_cnt !== 32'd0 || stat_drop_cnt !== 32'd0) begin errors++; $display("FAIL midrst_stats: got %0d/%0d/%0d want 0/0/0", stat_rule_cnt, stat_pkt_cnt, stat_drop_cnt); end
    rst = 1'b0;
    out_rule_ready = 1'b1;
    repeat (15) step();
    checks++; if (q.size() != 3) begin errors++; $display("FAIL midrst_no_more: got %0d beats want 3", q.size()); end
    if (q.size() == 3) begin
      checks++; if (q[0].id !== 16'd1 || q[1].id !== 16'd2 || q[2].id !== 16'd3) begin errors++; $display("FAIL midrst_first3: got %h %h %h want 1 2 3", q[0].id, q[1].id, q[2].id); end
    end
  endtask

  initial begin
    idle_inputs();
    out_rule_ready = 1'b1;
    rst = 1'b1;
    test_reset();
    test_basic();
    test_empty_word();
    test_back_to_back();
    test_stall();
    test_almost_full();
    test_late_meta();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
